// File: rtl/segdisplay_bcd_if.sv
// Handshake and display-write bundle for segdisplay_bcd.
// The master modport is the value producer / display consumer side;
// the slave modport is the converter itself.
interface segdisplay_bcd_if;
   logic [31:0] in_data_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] write_data_o;
   logic [3:0]  write_mask_o;
   logic        busy_o;

   modport master (
      output in_data_i,
      output in_valid_i,
      input  in_ready_o,
      input  write_data_o,
      input  write_mask_o,
      input  busy_o
   );

   modport slave (
      input  in_data_i,
      input  in_valid_i,
      output in_ready_o,
      output write_data_o,
      output write_mask_o,
      output busy_o
   );
endinterface

// File: rtl/segdisplay_bcd.sv
// Binary to packed-BCD converter feeding an 8-digit display write port.
// Iterative double-dabble over operand bits [26:0], one bit per clock.
// Out-of-range inputs (above MAX_VALUE) skip conversion and report a fixed
// pattern: all 'E' digits by default, or all '9' digits when the macro
// SEGDISPLAY_BCD_SATURATE_EN is defined.
module segdisplay_bcd #(
   parameter int unsigned MAX_VALUE = 99_999_999
) (
   input  logic           clk_i,
   input  logic           reset_ni,
   segdisplay_bcd_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_DONE    = 2'd2
   } state_e;

   localparam logic [31:0] MAX_V     = 32'(MAX_VALUE);
   localparam logic [4:0]  LAST_ITER = 5'd26;

`ifdef SEGDISPLAY_BCD_SATURATE_EN
   localparam logic [31:0] OOR_RESULT = 32'h9999_9999;
`else
   localparam logic [31:0] OOR_RESULT = 32'hEEEE_EEEE;
`endif

   state_e      state_q;
   logic [4:0]  cnt_q;
   logic [26:0] operand_q;
   logic [31:0] bcd_q;
   logic [31:0] bcd_next;
   logic [31:0] write_data_q;
   logic [3:0]  write_mask_q;
   logic        ready_q;
   logic        busy_q;
   logic        in_range;

   assign in_range = (bus.in_data_i <= MAX_V);

   // One double-dabble step: add 3 to every nibble >= 5, then shift in the next operand bit.
   always_comb begin
      logic [31:0] adj;
      // NOTE: combinational logic uses blocking '=' and assigns a default first, so no latch is inferred.
      adj = bcd_q;
      for (int i = 0; i < 8; i++) begin
         if (adj[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
         end
      end
      bcd_next = (adj << 1) | {31'b0, operand_q[26]};
   end

   // Control FSM, iteration datapath and registered outputs.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         // NOTE: operand_q and bcd_q are pure datapath, always reloaded at acceptance, so they carry no reset.
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         write_data_q <= '0;
         write_mask_q <= '0;
         ready_q      <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
         unique case (state_q)
            S_IDLE: begin
               if (bus.in_valid_i && ready_q) begin
                  operand_q <= bus.in_data_i[26:0];
                  bcd_q     <= '0;
                  cnt_q     <= '0;
                  ready_q   <= 1'b0;
                  busy_q    <= 1'b1;
                  if (in_range) begin
                     state_q <= S_CONVERT;
                  end else begin
                     // Result is loaded on entry; the strobe follows one cycle later.
                     state_q      <= S_DONE;
                     write_data_q <= OOR_RESULT;
                  end
               end
            end

            S_CONVERT: begin
               operand_q <= {operand_q[25:0], 1'b0};
               bcd_q     <= bcd_next;
               cnt_q     <= cnt_q + 5'd1;
               if (cnt_q == LAST_ITER) begin
                  state_q      <= S_DONE;
                  write_data_q <= bcd_next;
                  write_mask_q <= 4'hF;
               end
            end

            S_DONE: begin
               // Leave after the single strobe cycle; an out-of-range entry
               // arrives without a strobe and raises it here first.
               if (write_mask_q == 4'hF) begin
                  state_q      <= S_IDLE;
                  write_mask_q <= 4'h0;
                  ready_q      <= 1'b1;
                  busy_q       <= 1'b0;
               end else begin
                  write_mask_q <= 4'hF;
               end
            end

            default: begin
               state_q      <= S_IDLE;
               write_mask_q <= 4'h0;
               ready_q      <= 1'b1;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready_o   = ready_q;
   assign bus.busy_o       = busy_q;
   assign bus.write_data_o = write_data_q;
   assign bus.write_mask_o = write_mask_q;

endmodule

// File: tb/tb_segdisplay_bcd.sv
// Directed bench for segdisplay_bcd: reset, conversion timing, boundaries,
// out-of-range handling, mid-conversion reset, busy-time input, random values.
module tb_segdisplay_bcd;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

`ifdef SEGDISPLAY_BCD_SATURATE_EN
   localparam logic [31:0] OOR_EXP = 32'h9999_9999;
`else
   localparam logic [31:0] OOR_EXP = 32'hEEEE_EEEE;
`endif

   segdisplay_bcd_if bus ();

   segdisplay_bcd #(.MAX_VALUE(99_999_999)) dut (
      .clk_i    (clk),
      .reset_ni (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Decimal digits of v packed as BCD (reference model).
   function automatic logic [31:0] ref_bcd(input logic [31:0] v);
      logic [31:0] r = '0;
      logic [31:0] x = v;
      for (int d = 0; d < 8; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Send one value and observe the outcome; edges are counted from acceptance (E0).
   task automatic send_and_wait(input logic [31:0] value,
                                output int strobe_edge, output logic [31:0] strobe_data,
                                output logic [3:0] strobe_mask, output int strobes,
                                output int ready_edge, output logic busy_e0);
      int waited = 0;
      strobe_edge = -1; strobe_data = '0; strobe_mask = '0;
      strobes = 0; ready_edge = -1; busy_e0 = 1'b0;
      while (!bus.in_ready_o && waited < 50) begin
         tick();
         waited++;
      end
      if (!bus.in_ready_o) return;
      bus.in_data_i  = value;
      bus.in_valid_i = 1'b1;
      tick();
      bus.in_valid_i = 1'b0;
      busy_e0 = bus.busy_o;
      for (int k = 1; k <= 60 && ready_edge < 0; k++) begin
         tick();
         if (bus.write_mask_o != 4'h0) begin
            strobes++;
            if (strobe_edge < 0) begin
               strobe_edge = k;
               strobe_data = bus.write_data_o;
               strobe_mask = bus.write_mask_o;
            end
         end
         if (bus.in_ready_o) ready_edge = k;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = 32'd5;
      tick();
      tick();
      total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.in_ready_o); end
      total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy_o); end
      total++; if (bus.write_mask_o !== 4'h0) begin bad++; $display("FAIL reset_mask got=%h want=0", bus.write_mask_o); end
      total++; if (bus.write_data_o !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=00000000", bus.write_data_o); end
      bus.in_valid_i = 1'b0;
      rst_n = 1'b1;
      tick();
      total++; if (bus.in_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_release got ready=%b busy=%b want 1/0", bus.in_ready_o, bus.busy_o); end
   endtask

   task automatic test_convert(input logic [31:0] value, input logic [31:0] expected, input string name);
      int se, n, re; logic [31:0] sd; logic [3:0] sm; logic b0;
      send_and_wait(value, se, sd, sm, n, re, b0);
      total++; if (b0 !== 1'b1) begin bad++; $display("FAIL %s busy got=%b want=1", name, b0); end
      total++; if (se != 27) begin bad++; $display("FAIL %s strobe_edge got=%0d want=27", name, se); end
      total++; if (sd !== expected) begin bad++; $display("FAIL %s data got=%h want=%h", name, sd, expected); end
      total++; if (sm !== 4'hF) begin bad++; $display("FAIL %s mask got=%h want=f", name, sm); end
      total++; if (n != 1) begin bad++; $display("FAIL %s strobes got=%0d want=1", name, n); end
      total++; if (re != 28) begin bad++; $display("FAIL %s ready_edge got=%0d want=28", name, re); end
      total++; if (bus.write_data_o !== expected) begin bad++; $display("FAIL %s hold got=%h want=%h", name, bus.write_data_o, expected); end
   endtask

   task automatic test_zero_and_max();
      test_convert(32'd0, 32'h0000_0000, "zero");
      test_convert(32'd99_999_999, 32'h9999_9999, "max");
   endtask

   task automatic test_out_of_range(input logic [31:0] value, input string name);
      int se, n, re; logic [31:0] sd; logic [3:0] sm; logic b0;
      send_and_wait(value, se, sd, sm, n, re, b0);
      total++; if (b0 !== 1'b1) begin bad++; $display("FAIL %s busy got=%b want=1", name, b0); end
      total++; if (se != 1) begin bad++; $display("FAIL %s strobe_edge got=%0d want=1", name, se); end
      total++; if (sd !== OOR_EXP) begin bad++; $display("FAIL %s data got=%h want=%h", name, sd, OOR_EXP); end
      total++; if (n != 1 || sm !== 4'hF) begin bad++; $display("FAIL %s strobes got=%0d mask=%h want 1/f", name, n, sm); end
      total++; if (re != 2) begin bad++; $display("FAIL %s ready_edge got=%0d want=2", name, re); end
   endtask

   task automatic test_reset_mid();
      int strobes = 0;
      bus.in_data_i  = 32'd12_345_678;
      bus.in_valid_i = 1'b1;
      tick();                           // E0
      bus.in_valid_i = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (bus.write_mask_o != 4'h0) strobes++;
      end
      rst_n = 1'b0;
      tick();                           // E10 with reset low
      rst_n = 1'b1;
      total++; if (bus.in_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin bad++; $display("FAIL midreset_state got ready=%b busy=%b want 1/0", bus.in_ready_o, bus.busy_o); end
      total++; if (bus.write_data_o !== 32'h0) begin bad++; $display("FAIL midreset_data got=%h want=00000000", bus.write_data_o); end
      for (int k = 0; k < 30; k++) begin
         if (bus.write_mask_o != 4'h0) strobes++;
         tick();
      end
      total++; if (strobes != 0) begin bad++; $display("FAIL midreset_strobe got=%0d want=0", strobes); end
      test_convert(32'd87_654_321, 32'h8765_4321, "after_reset");
   endtask

   task automatic test_back_to_back();
      int se = -1;
      logic [31:0] sd = '0;
      while (!bus.in_ready_o) tick();
      bus.in_data_i  = 32'd11_111_111;
      bus.in_valid_i = 1'b1;
      tick();                           // E0
      for (int k = 1; k <= 27; k++) begin
         bus.in_data_i = (k % 2 == 1) ? 32'd22_222_222 : 32'd44_444_444;
         if (k == 27) bus.in_data_i = 32'd33_333_333;
         tick();
      end
      total++; if (bus.write_mask_o !== 4'hF || bus.write_data_o !== 32'h1111_1111) begin bad++; $display("FAIL b2b_first got mask=%h data=%h want f/11111111", bus.write_mask_o, bus.write_data_o); end
      tick();                           // E28
      total++; if (bus.in_ready_o !== 1'b1 || bus.write_mask_o !== 4'h0) begin bad++; $display("FAIL b2b_idle got ready=%b mask=%h want 1/0", bus.in_ready_o, bus.write_mask_o); end
      tick();                           // next acceptance
      bus.in_valid_i = 1'b0;
      total++; if (bus.in_ready_o !== 1'b0 || bus.busy_o !== 1'b1) begin bad++; $display("FAIL b2b_accept got ready=%b busy=%b want 0/1", bus.in_ready_o, bus.busy_o); end
      for (int k = 1; k <= 40 && se < 0; k++) begin
         tick();
         if (bus.write_mask_o == 4'hF) begin se = k; sd = bus.write_data_o; end
      end
      total++; if (se != 27 || sd !== 32'h3333_3333) begin bad++; $display("FAIL b2b_second got edge=%0d data=%h want 27/33333333", se, sd); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         logic [31:0] v = 32'($urandom_range(0, 99_999_999));
         logic [31:0] exp_v = ref_bcd(v);
         int se, n, re; logic [31:0] sd; logic [3:0] sm; logic b0;
         logic nib_ok = 1'b1;
         send_and_wait(v, se, sd, sm, n, re, b0);
         for (int d = 0; d < 8; d++) if (sd[4*d +: 4] > 4'd9) nib_ok = 1'b0;
         total++; if (!nib_ok) begin bad++; $display("FAIL rand_nibble in=%0d got=%h want digits<=9", v, sd); end
         total++; if (sd !== exp_v || se != 27) begin bad++; $display("FAIL rand_value in=%0d got=%h edge=%0d want=%h edge=27", v, sd, se, exp_v); end
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.in_valid_i = 1'b0;
      bus.in_data_i  = '0;
      test_reset();
      test_convert(32'd12_345_678, 32'h1234_5678, "convert_12345678");
      test_zero_and_max();
      test_out_of_range(32'd100_000_000, "oor_min");
      test_out_of_range(32'hFFFF_FFFF, "oor_max");
      test_convert(32'd10_000_005, 32'h1000_0005, "after_oor");
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/segdisplay_bcd.md
SEGDISPLAY_BCD -- requirements
Module: segdisplay_bcd

Interface
REQ-001 SHALL have parameter MAX_VALUE, default 99_999_999, meaning the largest input converted normally; a larger input is out-of-range.
REQ-002 SHALL have port clk_i  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_ni  input  1  synchronous, active-low reset.
REQ-004 SHALL have port in_data_i  input  32  unsigned binary value to display.
REQ-005 SHALL have port in_valid_i  input  1  in_data_i is valid.
REQ-006 SHALL have port in_ready_o  output  1  block can accept a value.
REQ-007 SHALL have port write_data_o  output  32  packed BCD; digit k is in bits [4k+3:4k], digit 0 is least significant. It feeds the display write data.
REQ-008 SHALL have port write_mask_o  output  4  byte write strobes; they feed the display write mask.
REQ-009 SHALL have port busy_o  output  1  a conversion is in progress.

Function
REQ-010 SHALL implement the states IDLE, CONVERT and DONE with a registered state.
REQ-011 SHALL drive in_ready_o high only in IDLE.
REQ-012 SHALL drive busy_o high only in CONVERT or DONE.
REQ-013 SHALL accept an input on a rising edge where in_valid_i and in_ready_o are both high (acceptance edge, E0), and SHALL latch in_data_i on that edge.
REQ-014 SHALL ignore in_valid_i in every state except IDLE; the latched operand is not disturbed.
REQ-015 SHALL go from IDLE to CONVERT at E0 for an in-range value (in_data_i <= MAX_VALUE).
REQ-016 SHALL go from IDLE directly to DONE at E0 for an out-of-range value.
REQ-017 SHALL convert by iterative double-dabble over input bits [26:0], MSB first, one bit per edge: add-3 to each BCD nibble >= 5, then shift left one bit.
REQ-018 SHALL use a 5-bit iteration counter, reset to 0 at E0, and SHALL run exactly 27 iterations at edges E1..E27.
REQ-019 SHALL go from CONVERT to DONE at E27.
REQ-020 SHALL drive write_mask_o = 4'hF for exactly one cycle, while in DONE, and 4'h0 in every other cycle.
REQ-021 SHALL present the result on write_data_o in that same DONE cycle.
REQ-022 SHALL go from DONE to IDLE on the next edge, so in_ready_o is high again from E28 (in range) or E2 (out of range).
REQ-023 SHALL hold write_data_o at the last result outside DONE and SHALL change it only on entry to DONE.
REQ-024 SHALL produce 0x00000000 for input 0 and SHALL require no special case for it.
REQ-025 SHALL size the BCD accumulator at 32 bits; no nibble may exceed 9 after the final shift for any in-range input.

Reset
REQ-026 SHALL, with reset_ni low on a rising edge, set state to IDLE, the counter to 0, write_data_o to 0x00000000 and write_mask_o to 4'h0.
REQ-027 SHALL, with reset_ni low on a rising edge, set in_ready_o high and busy_o low from the following cycle.
REQ-028 SHALL abandon any conversion in progress on reset and SHALL NOT produce a write_mask_o strobe for it.
REQ-029 SHALL give reset priority over acceptance on the same edge.

Configuration
REQ-030 SHALL use macro SEGDISPLAY_BCD_SATURATE_EN to select the out-of-range result.
REQ-031 SHALL, when SEGDISPLAY_BCD_SATURATE_EN is defined, produce 0x99999999 for an out-of-range input.
REQ-032 SHALL, when SEGDISPLAY_BCD_SATURATE_EN is not defined, produce 0xEEEEEEEE (all digits 'E', error) for an out-of-range input.
REQ-033 SHALL have identical timing for an out-of-range input in both builds.

Verification
REQ-034 SHALL cover: in_data_i = 12_345_678 accepted at E0 -> write_mask_o = F and write_data_o = 0x12345678 in the cycle after E27 only; in_ready_o high from E28.
REQ-035 SHALL cover: in_data_i = 0, then in_data_i = 99_999_999 -> 0x00000000, then 0x99999999; each strobes exactly once.
REQ-036 SHALL cover: in_data_i = 100_000_000 -> 0xEEEEEEEE strobed in the cycle after E1 (0x99999999 with SEGDISPLAY_BCD_SATURATE_EN); in_ready_o high from E2.
REQ-037 SHALL cover: reset_ni low at E10 of a conversion -> no strobe; write_data_o = 0; in_ready_o high the cycle after; the next input converts normally.
REQ-038 SHALL cover: in_valid_i held high with a changing in_data_i during CONVERT -> only the E0 value is converted; the next value is accepted at E28.
REQ-039 SHALL cover: random in-range values checked against a reference model -> every write_data_o nibble <= 9 and equal to the decimal digits of the input.
